interval_timer: RTL and testbench

//  Seconds countdown timer between the controller FSM and the time-parameter store.
//  On a start request it drives the store's 2-bit Interval select and captures the returned 4-bit Value.
//  It then counts Value seconds on an internal 1 Hz tick and pulses Expired so the FSM can advance.

---
 rtl/interval_timer_pkg.sv | 23 ++
 rtl/interval_timer_one_hz_divider.sv | 34 +++
 rtl/interval_timer.sv | 105 ++++++++++
 tb/tb_interval_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared definitions for the traffic-light controller timing path.
// Holds the interval selector codes used by the FSM, this timer and the time-parameter store,
// the timer state encoding, and a helper that maps a zero duration onto one second.
package tlc_defs;

  // Interval selector codes driven to the time-parameter store.
  localparam logic [1:0] SELECTOR_BASE = 2'b00;
  localparam logic [1:0] SELECTOR_EXT  = 2'b01;
  localparam logic [1:0] SELECTOR_YEL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_FETCH  = 2'd2,
    ST_COUNT  = 2'd3
  } timer_state_t;

  // A zero-length interval would never expire, so it is stretched to one second.
  function automatic logic [3:0] nonzero_secs(input logic [3:0] secs);
    return (secs == 4'd0) ? 4'd1 : secs;
  endfunction

endpackage

// File: rtl/interval_timer_one_hz_divider.sv
// one_hz_divider: prescaler producing a one-cycle Tick every CYCLES_PER_SEC enabled cycles.
// Ports: clock, Reset_Sync (async, active high), Clear (restart the second), Enable (count),
//        Tick (high during the terminal-count cycle while enabled).
module one_hz_divider #(
  parameter int CYCLES_PER_SEC = 100_000_000,
  parameter int PRESC_W        = 27
) (
  input  logic clock,
  input  logic Reset_Sync,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(CYCLES_PER_SEC - 1);

  logic [PRESC_W-1:0] presc;

  // Tick is decoded from the count register; the timer consumes it on the same edge the
  // prescaler wraps, so the second boundary and the Remaining update line up.
  assign Tick = Enable && (presc == TERMINAL);

  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      presc <= '0;
    end else if (Clear) begin
      presc <= '0;
    end else if (Enable) begin
      if (presc == TERMINAL) presc <= '0;
      else                   presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// interval_timer: seconds countdown between the controller FSM and the time-parameter store.
// Ports: clock, Reset_Sync (async, active high), Start_Timer/Interval_Req (request from FSM),
//        Value (seconds from store), Interval (select to store), Remaining, Busy, Expired (pulse).
module interval_timer
  import tlc_defs::*;
#(
  parameter int CYCLES_PER_SEC = 100_000_000,
  parameter int PRESC_W        = 27
) (
  input  logic       clock,
  input  logic       Reset_Sync,
  input  logic       Start_Timer,
  input  logic [1:0] Interval_Req,
  input  logic [3:0] Value,
  output logic [1:0] Interval,
  output logic [3:0] Remaining,
  output logic       Busy,
  output logic       Expired
);

  timer_state_t state, state_nxt;
  logic [1:0]   interval_nxt;
  logic [3:0]   remaining_nxt;
  logic         expired_nxt;
  logic         div_clear;
  logic         div_enable;
  logic         tick;

  one_hz_divider #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC),
    .PRESC_W       (PRESC_W)
  ) u_divider (
    .clock     (clock),
    .Reset_Sync(Reset_Sync),
    .Clear     (div_clear),
    .Enable    (div_enable),
    .Tick      (tick)
  );

  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    interval_nxt  = Interval;
    remaining_nxt = Remaining;
    expired_nxt   = 1'b0;
    div_clear     = 1'b0;
    div_enable    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (Start_Timer) begin
          state_nxt    = ST_SELECT;
          interval_nxt = Interval_Req;
        end
      end
      // The store registers Interval on the edge leaving SELECT.
      ST_SELECT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        remaining_nxt = nonzero_secs(Value);
        div_clear     = 1'b1;
        state_nxt     = ST_COUNT;
      end
      ST_COUNT: begin
        div_enable = 1'b1;
        if (tick) begin
          if (Remaining <= 4'd1) begin
            remaining_nxt = 4'd0;
            expired_nxt   = 1'b1;
            state_nxt     = ST_IDLE;
          end else begin
            remaining_nxt = Remaining - 4'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A request while active restarts the sequence. It only redirects the state and the
    // selector: an expiry on this edge still pulses, giving back-to-back chaining.
    if (Start_Timer && (state != ST_IDLE)) begin
      state_nxt    = ST_SELECT;
      interval_nxt = Interval_Req;
    end
  end

  // All outputs come straight from flops; Busy is registered from the next state.
  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      Interval  <= SELECTOR_BASE;
      Remaining <= 4'd0;
      Busy      <= 1'b0;
      Expired   <= 1'b0;
    end else begin
      Interval  <= interval_nxt;
      Remaining <= remaining_nxt;
      Busy      <= (state_nxt != ST_IDLE);
      Expired   <= expired_nxt;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
module tb_interval_timer;

  localparam int C = 4;

  logic       clock = 1'b0;
  logic       Reset_Sync;
  logic       Start_Timer;
  logic [1:0] Interval_Req;
  logic [3:0] Value;
  logic [1:0] Interval;
  logic [3:0] Remaining;
  logic       Busy;
  logic       Expired;

  int errors = 0;
  int checks = 0;

  interval_timer #(.CYCLES_PER_SEC(C), .PRESC_W(2)) dut (
    .clock       (clock),
    .Reset_Sync  (Reset_Sync),
    .Start_Timer (Start_Timer),
    .Interval_Req(Interval_Req),
    .Value       (Value),
    .Interval    (Interval),
    .Remaining   (Remaining),
    .Busy        (Busy),
    .Expired     (Expired)
  );

  always #5 clock = ~clock;

  // Time-parameter store: one-cycle registered lookup of the selected interval.
  logic [3:0] tbl [4];
  always @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) Value <= 4'd0;
    else            Value <= tbl[Interval];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  // Reference model: a request accepted on edge t0 latches the table entry on edge t0+1,
  // captures it on edge t0+2 and expires N*C edges after the capture.
  typedef struct {
    logic [3:0] rem;
    logic       busy;
    logic       exp;
    logic [1:0] itv;
  } exp_t;

  exp_t sbq[$];
  int   e, t0, cap, n, nlat;
  bit   act;
  logic [3:0] m_rem;
  logic [1:0] m_int;
  logic       m_exp;

  always @(posedge clock or posedge Reset_Sync) begin
    exp_t x;
    if (Reset_Sync) begin
      e = 0; t0 = 0; cap = 0; n = 0; nlat = 0; act = 0;
      m_rem = 0; m_int = 0; m_exp = 0;
      sbq.delete();
    end else begin
      m_exp = 0;
      if (act && e == t0 + 1) nlat = (tbl[m_int] == 0) ? 1 : int'(tbl[m_int]);
      if (act && e >= cap) begin
        if (e == cap) n = nlat;
        if (e == cap + n * C) begin
          m_exp = 1; m_rem = 0; act = 0;
        end else begin
          m_rem = 4'(n - (e - cap) / C);
        end
      end
      if (Start_Timer) begin
        act = 1; t0 = e; cap = e + 2; m_int = Interval_Req;
      end
      x.rem = m_rem; x.busy = act; x.exp = m_exp; x.itv = m_int;
      sbq.push_back(x);
      e++;
    end
  end

  // Monitor: compares every registered output cycle against the expected queue.
  always @(negedge clock) begin
    exp_t x;
    if (!Reset_Sync && sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("expired",   32'(Expired),   32'(x.exp));
      chk("busy",      32'(Busy),      32'(x.busy));
      chk("remaining", 32'(Remaining), 32'(x.rem));
      chk("interval",  32'(Interval),  32'(x.itv));
    end
  end

  task automatic cyc(input bit s, input logic [1:0] r);
    @(negedge clock);
    #1;
    Start_Timer  = s;
    Interval_Req = r;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 2'b00);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_interval"},  32'(Interval),  32'd0);
    chk({tag, "_remaining"}, 32'(Remaining), 32'd0);
    chk({tag, "_busy"},      32'(Busy),      32'd0);
    chk({tag, "_expired"},   32'(Expired),   32'd0);
  endtask

  initial begin
    Reset_Sync   = 1'b1;
    Start_Timer  = 1'b0;
    Interval_Req = 2'b00;
    tbl[0] = 4'd6; tbl[1] = 4'd3; tbl[2] = 4'd2; tbl[3] = 4'd5;
    #1;
    chk_zero("reset");
    #11;
    Reset_Sync = 1'b0;

    // BASE, 6 seconds
    cyc(1'b1, 2'b00); idle(30);
    // YEL, 2 seconds
    cyc(1'b1, 2'b10); idle(12);
    // zero loads one second, then the 15 s maximum
    tbl[0] = 4'd0;  cyc(1'b1, 2'b00); idle(8);
    tbl[0] = 4'd15; cyc(1'b1, 2'b00); idle(65);
    // EXT aborted by YEL five cycles later
    tbl[0] = 4'd6;
    cyc(1'b1, 2'b01); idle(4); cyc(1'b1, 2'b10); idle(14);
    // restart on the expiry cycle of a 1 s BASE interval
    tbl[0] = 4'd1;
    cyc(1'b1, 2'b00); idle(5); cyc(1'b1, 2'b10); idle(14);
    // reset in the middle of counting, between clock edges
    tbl[0] = 4'd6;
    cyc(1'b1, 2'b00); idle(10);
    @(negedge clock); #2;
    Reset_Sync  = 1'b1;
    Start_Timer = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clock); #1;
    Reset_Sync = 1'b0;
    idle(30);
    // reprogramming the store while counting has no effect
    tbl[2] = 4'd3;
    cyc(1'b1, 2'b10); idle(6);
    tbl[2] = 4'd9; idle(14);

    // randomized requests and store contents
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 9) == 0) tbl[j] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) cyc(1'b1, 2'($urandom_range(0, 3)));
      else                            cyc(1'b0, 2'($urandom_range(0, 3)));
    end
    idle(70);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
